matrix_frame_arbiter: RTL and testbench

- Sits between the 2048 game logic and the 8x8 LED matrix scanner.
- Owns the 64-bit tile frame (4x4 tiles, 4-bit codes) that feeds the scanner's mat_flat input.
- Shares the display between two requesters: the game board and a timed overlay (e.g. game-over or win screen).
- Updates the frame only at frame boundaries, so there is no tearing mid-scan.

---
 rtl/matrix_pkg.sv | 26 ++
 rtl/matrix_frame_timer.sv | 33 +++
 rtl/matrix_frame_arbiter.sv | 178 +++++++++++++++++
 tb/tb_matrix_frame_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the LED matrix frame path.
// Contents: tile/grid geometry, arbiter state encoding and a helper
// that builds a frame with every tile set to the same code.
package matrix_pkg;

  localparam int TILE_W = 4;
  localparam int GRID   = 4;
  localparam int MAT_W  = TILE_W * GRID * GRID;

  typedef enum logic [1:0] {
    BOARD    = 2'd0,
    OVL_WAIT = 2'd1,
    OVERLAY  = 2'd2
  } arb_state_e;

  // Replicate one tile code into all 16 tile slots of a frame.
  function automatic logic [MAT_W-1:0] blank_frame(input logic [TILE_W-1:0] tile);
    logic [MAT_W-1:0] frame;
    frame = '0;
    for (int i = 0; i < GRID * GRID; i++) begin
      frame[i*TILE_W +: TILE_W] = tile;
    end
    return frame;
  endfunction

endpackage

// File: rtl/matrix_frame_timer.sv
// Display frame timer, shared with the row scanner.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   fcnt        : cycle position inside the frame, 0..FRAME_CYCLES-1
//   frame_start : high exactly while fcnt == FRAME_CYCLES-1 (boundary cycle)
module matrix_frame_timer #(
  parameter int FRAME_CYCLES = 1048576,
  localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] fcnt,
  output logic             frame_start
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYCLES - 1);

  // Frame counter; frame_start is registered one cycle ahead so it
  // coincides with fcnt == LAST without a combinational decode on the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt        <= '0;
      frame_start <= 1'b0;
    end else if (fcnt == LAST) begin
      fcnt        <= '0;
      frame_start <= 1'b0;
    end else begin
      fcnt        <= fcnt + CNT_W'(1);
      frame_start <= (fcnt == (LAST - CNT_W'(1)));
    end
  end

endmodule

// File: rtl/matrix_frame_arbiter.sv
// Frame owner between the 2048 game logic and the LED matrix scanner.
// Shares the display between the game board and a timed overlay and only
// changes mat_flat on frame boundaries so a scan never tears.
// Ports:
//   clk, reset        : system clock, synchronous active-high reset
//   board_flat/vld/rdy: board handshake into a single pending slot
//   ovl_req/flat/frames: overlay request, frame and duration (frames)
//   ovl_gnt           : one-cycle pulse, overlay accepted
//   ovl_done          : one-cycle pulse, overlay finished, board restored
//   mat_flat          : frame to the scanner
//   frame_start       : one-cycle pulse on the boundary cycle
// Build option: define MATRIX_ARB_BLINK_EN to make the overlay alternate
// with an all-blank frame on every other displayed frame.
module matrix_frame_arbiter
  import matrix_pkg::*;
#(
  parameter int                FRAME_CYCLES = 1048576,
  parameter int                HOLD_W       = 8,
  parameter logic [TILE_W-1:0] BLANK_TILE   = 4'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MAT_W-1:0]  board_flat,
  input  logic              board_vld,
  output logic              board_rdy,
  input  logic              ovl_req,
  input  logic [MAT_W-1:0]  ovl_flat,
  input  logic [HOLD_W-1:0] ovl_frames,
  output logic              ovl_gnt,
  output logic              ovl_done,
  output logic [MAT_W-1:0]  mat_flat,
  output logic              frame_start
);

  localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [MAT_W-1:0] BLANK_FRAME = blank_frame(BLANK_TILE);

  logic [CNT_W-1:0]  fcnt_unused_s;
  logic              boundary_s;

  arb_state_e        state_r,     state_n;
  logic [MAT_W-1:0]  mat_r,       mat_n;
  logic [MAT_W-1:0]  cur_board_r, cur_board_n;
  logic [MAT_W-1:0]  pend_r,      pend_n;
  logic              pend_full_r, pend_full_n;
  logic [MAT_W-1:0]  ovl_buf_r,   ovl_buf_n;
  logic [HOLD_W-1:0] remain_r,    remain_n;
  logic              gnt_s,       done_s;
`ifdef MATRIX_ARB_BLINK_EN
  // High when the next overlay frame index is odd (shown blank).
  logic              blink_r,     blink_n;
`endif

  matrix_frame_timer #(.FRAME_CYCLES(FRAME_CYCLES)) u_timer (
    .clk         (clk),
    .reset       (reset),
    .fcnt        (fcnt_unused_s),
    .frame_start (boundary_s)
  );

  assign board_rdy   = !pend_full_r;
  assign ovl_gnt     = gnt_s;
  assign ovl_done    = done_s;
  assign mat_flat    = mat_r;
  assign frame_start = boundary_s;

  // Next-state, frame selection and handshake decode.
  always_comb begin
    state_n     = state_r;
    mat_n       = mat_r;
    cur_board_n = cur_board_r;
    pend_n      = pend_r;
    pend_full_n = pend_full_r;
    ovl_buf_n   = ovl_buf_r;
    remain_n    = remain_r;
    gnt_s       = 1'b0;
    done_s      = 1'b0;
`ifdef MATRIX_ARB_BLINK_EN
    blink_n     = blink_r;
`endif

    case (state_r)
      BOARD: begin
        if (boundary_s && pend_full_r) begin
          mat_n       = pend_r;
          cur_board_n = pend_r;
          pend_full_n = 1'b0;
        end else begin
          mat_n = mat_r;
        end
        if (ovl_req) begin
          gnt_s     = 1'b1;
          ovl_buf_n = ovl_flat;
          remain_n  = (ovl_frames == '0) ? HOLD_W'(1) : ovl_frames;
          state_n   = OVL_WAIT;
        end else begin
          state_n = BOARD;
        end
      end
      OVL_WAIT: begin
        // Overlay wins this boundary; any pending board waits for the end.
        if (boundary_s) begin
          mat_n   = ovl_buf_r;
          state_n = OVERLAY;
`ifdef MATRIX_ARB_BLINK_EN
          blink_n = 1'b1;
`endif
        end else begin
          state_n = OVL_WAIT;
        end
      end
      OVERLAY: begin
        if (boundary_s && (remain_r > HOLD_W'(1))) begin
          remain_n = remain_r - HOLD_W'(1);
`ifdef MATRIX_ARB_BLINK_EN
          mat_n    = blink_r ? BLANK_FRAME : ovl_buf_r;
          blink_n  = !blink_r;
`else
          mat_n    = ovl_buf_r;
`endif
        end else if (boundary_s) begin
          // Last overlay frame ends: newest board wins over the saved one.
          if (pend_full_r) begin
            mat_n       = pend_r;
            cur_board_n = pend_r;
            pend_full_n = 1'b0;
          end else begin
            mat_n = cur_board_r;
          end
          remain_n = '0;
          done_s   = 1'b1;
          state_n  = BOARD;
        end else begin
          state_n = OVERLAY;
        end
      end
      default: begin
        state_n = BOARD;
      end
    endcase

    // Slot is only loaded while empty, so this never races a commit.
    if (board_vld && !pend_full_r) begin
      pend_n      = board_flat;
      pend_full_n = 1'b1;
    end else begin
      pend_n = pend_n;
    end
  end

  // State and frame registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= BOARD;
      mat_r       <= BLANK_FRAME;
      cur_board_r <= BLANK_FRAME;
      pend_r      <= '0;
      pend_full_r <= 1'b0;
      ovl_buf_r   <= '0;
      remain_r    <= '0;
`ifdef MATRIX_ARB_BLINK_EN
      blink_r     <= 1'b0;
`endif
    end else begin
      state_r     <= state_n;
      mat_r       <= mat_n;
      cur_board_r <= cur_board_n;
      pend_r      <= pend_n;
      pend_full_r <= pend_full_n;
      ovl_buf_r   <= ovl_buf_n;
      remain_r    <= remain_n;
`ifdef MATRIX_ARB_BLINK_EN
      blink_r     <= blink_n;
`endif
    end
  end

endmodule

// File: tb/tb_matrix_frame_arbiter.sv
// Directed self-checking bench for matrix_frame_arbiter with 16-cycle frames.
module tb_matrix_frame_arbiter;

  logic        clk;
  logic        reset;
  logic [63:0] board_flat;
  logic        board_vld;
  logic        board_rdy;
  logic        ovl_req;
  logic [63:0] ovl_flat;
  logic [7:0]  ovl_frames;
  logic        ovl_gnt;
  logic        ovl_done;
  logic [63:0] mat_flat;
  logic        frame_start;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  localparam logic [63:0] BRD_A = 64'h0123_4567_89AB_0000;
  localparam logic [63:0] BRD_B = 64'h1111_2222_3333_4444;
  localparam logic [63:0] BRD_C = 64'h5555_6666_7777_8888;
  localparam logic [63:0] BRD_D = 64'h9999_AAAA_BBBB_CCCC;
  localparam logic [63:0] OVL_F = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] OVL_5 = 64'hA5A5_A5A5_A5A5_A5A5;

  matrix_frame_arbiter #(
    .FRAME_CYCLES (16),
    .HOLD_W       (8),
    .BLANK_TILE   (4'd0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .board_flat  (board_flat),
    .board_vld   (board_vld),
    .board_rdy   (board_rdy),
    .ovl_req     (ovl_req),
    .ovl_flat    (ovl_flat),
    .ovl_frames  (ovl_frames),
    .ovl_gnt     (ovl_gnt),
    .ovl_done    (ovl_done),
    .mat_flat    (mat_flat),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Advance to the given cycle; samples/drives happen 1 time unit after posedge.
  task automatic tick_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    logic [63:0] exp_k1;
    reset      = 1'b1;
    board_flat = 64'h0;
    board_vld  = 1'b0;
    ovl_req    = 1'b0;
    ovl_flat   = 64'h0;
    ovl_frames = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;

    check_eq("rst_mat",  mat_flat, 64'h0);
    check_eq("rst_rdy",  {63'd0, board_rdy}, 64'd1);
    check_eq("rst_fs",   {63'd0, frame_start}, 64'd0);
    check_eq("rst_gnt",  {63'd0, ovl_gnt}, 64'd0);
    check_eq("rst_done", {63'd0, ovl_done}, 64'd0);

    // First board, then a second one while the slot is full.
    tick_to(3);  board_flat = BRD_A; board_vld = 1'b1;
    tick_to(4);  board_vld = 1'b0;
    check_eq("rdy_after_push", {63'd0, board_rdy}, 64'd0);
    tick_to(10); board_flat = BRD_B; board_vld = 1'b1;
    check_eq("rdy_full_hold", {63'd0, board_rdy}, 64'd0);
    tick_to(14); check_eq("fs_c14", {63'd0, frame_start}, 64'd0);
    tick_to(15);
    check_eq("fs_c15", {63'd0, frame_start}, 64'd1);
    check_eq("mat_c15", mat_flat, 64'h0);
    tick_to(16);
    check_eq("mat_a", mat_flat, BRD_A);
    check_eq("rdy_c16", {63'd0, board_rdy}, 64'd1);
    check_eq("fs_c16", {63'd0, frame_start}, 64'd0);
    tick_to(17);
    check_eq("rdy_b_taken", {63'd0, board_rdy}, 64'd0);
    board_vld = 1'b0;
    tick_to(31);
    check_eq("fs_c31", {63'd0, frame_start}, 64'd1);
    check_eq("mat_c31", mat_flat, BRD_A);
    tick_to(32);
    check_eq("mat_b", mat_flat, BRD_B);
    check_eq("rdy_c32", {63'd0, board_rdy}, 64'd1);

    // Overlay of 3 frames.
    tick_to(33);
    ovl_req = 1'b1; ovl_frames = 8'd3; ovl_flat = OVL_F;
    #1;
    check_eq("gnt_c33", {63'd0, ovl_gnt}, 64'd1);
    tick_to(34);
    ovl_req = 1'b0;
    #1;
    check_eq("gnt_c34", {63'd0, ovl_gnt}, 64'd0);
    tick_to(47); check_eq("mat_c47", mat_flat, BRD_B);
    tick_to(48); check_eq("ovl_k0", mat_flat, OVL_F);
`ifdef MATRIX_ARB_BLINK_EN
    exp_k1 = 64'h0;
`else
    exp_k1 = OVL_F;
`endif
    tick_to(64); check_eq("ovl_k1", mat_flat, exp_k1);
    tick_to(80); check_eq("ovl_k2", mat_flat, OVL_F);
    tick_to(94); check_eq("done_c94", {63'd0, ovl_done}, 64'd0);
    tick_to(95);
    check_eq("done_c95", {63'd0, ovl_done}, 64'd1);
    check_eq("mat_c95", mat_flat, OVL_F);
    tick_to(96);
    check_eq("done_c96", {63'd0, ovl_done}, 64'd0);
    check_eq("restore_b", mat_flat, BRD_B);

    // Zero-length overlay (treated as one frame), board pushed meanwhile.
    ovl_req = 1'b1; ovl_frames = 8'd0; ovl_flat = OVL_5;
    #1;
    check_eq("gnt_c96", {63'd0, ovl_gnt}, 64'd1);
    tick_to(97);  ovl_req = 1'b0;
    tick_to(100); board_flat = BRD_C; board_vld = 1'b1;
    tick_to(101); board_vld = 1'b0;
    check_eq("rdy_c101", {63'd0, board_rdy}, 64'd0);
    tick_to(111); check_eq("mat_c111", mat_flat, BRD_B);
    tick_to(112);
    check_eq("ovl0_shown", mat_flat, OVL_5);
    check_eq("rdy_c112", {63'd0, board_rdy}, 64'd0);
    tick_to(127); check_eq("done_c127", {63'd0, ovl_done}, 64'd1);
    tick_to(128);
    check_eq("mat_c", mat_flat, BRD_C);
    check_eq("rdy_c128", {63'd0, board_rdy}, 64'd1);
    check_eq("done_c128", {63'd0, ovl_done}, 64'd0);

    // Overlay aborted by reset with a board pending.
    ovl_req = 1'b1; ovl_frames = 8'd5; ovl_flat = OVL_F;
    #1;
    check_eq("gnt_c128", {63'd0, ovl_gnt}, 64'd1);
    tick_to(129); ovl_req = 1'b0;
    tick_to(144); check_eq("ovl_c144", mat_flat, OVL_F);
    tick_to(145); board_flat = BRD_D; board_vld = 1'b1;
    tick_to(146); board_vld = 1'b0;
    check_eq("rdy_c146", {63'd0, board_rdy}, 64'd0);
    tick_to(150); reset = 1'b1;
    tick_to(151);
    check_eq("mid_rst_mat",  mat_flat, 64'h0);
    check_eq("mid_rst_rdy",  {63'd0, board_rdy}, 64'd1);
    check_eq("mid_rst_fs",   {63'd0, frame_start}, 64'd0);
    check_eq("mid_rst_done", {63'd0, ovl_done}, 64'd0);
    reset = 1'b0;
    cyc   = 0;
    for (int i = 1; i <= 40; i++) begin
      tick_to(i);
      check_eq("post_rst_done", {63'd0, ovl_done}, 64'd0);
      check_eq("post_rst_fs", {63'd0, frame_start}, {63'd0, (i % 16) == 15});
      if (i == 16 || i == 32) begin
        check_eq("post_rst_mat", mat_flat, 64'h0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
